// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: word-addressed data memory for LW/SW,
// branch select back to fetch, the MEM/WB pipeline register and a post-reset clear sweep.
module mem_stage #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_ctl,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2,
    input  logic [4:0]  five_bit_muxout,
    output logic        MEM_PCSrc,
    output logic        mem_busy,
    output logic        mem_fault,
    output logic        MEM_WB_regwrite,
    output logic        MEM_WB_memtoreg,
    output logic [31:0] read_data,
    output logic [31:0] mem_alu_result,
    output logic [4:0]  MEM_WB_rd
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_ptr_q;
    logic                busy_q;
    logic                fault_q;
    logic                regwrite_q;
    logic                memtoreg_q;
    logic [31:0]         read_data_q;
    logic [31:0]         alu_q;
    logic [4:0]          rd_q;
    logic [31:0]         mem_q [DEPTH];

    logic                run_s;
    logic                bad_s;
    logic [ADDR_W-1:0]   idx_s;
    logic                mem_we_d;
    logic [ADDR_W-1:0]   mem_waddr_d;
    logic [31:0]         mem_wdata_d;

    // Access decode: word index and misaligned/out-of-range detection.
    always_comb begin
        run_s = (state_q == ST_RUN);
        idx_s = alu_result[ADDR_W+1:2];
        bad_s = (memread | memwrite) &
                ((alu_result[1:0] != 2'b00) | (|alu_result[31:ADDR_W+2]));
    end

    // Single memory write port shared by the clear sweep and RUN stores.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = idx_s;
        mem_wdata_d = rdata2;
        if (rst) begin
            mem_we_d = 1'b0;
        end else if (!run_s) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = clr_ptr_q;
            mem_wdata_d = 32'h0000_0000;
        end else begin
            mem_we_d = memwrite & ~bad_s;
        end
    end

    // Branch select is only meaningful once the memory is usable.
    always_comb begin
        MEM_PCSrc = run_s & branch & zero;
    end

    // Data memory array; no reset, contents defined by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    // Control FSM, fault flag and MEM/WB pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            clr_ptr_q   <= '0;
            busy_q      <= 1'b1;
            fault_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            read_data_q <= 32'h0000_0000;
            alu_q       <= 32'h0000_0000;
            rd_q        <= 5'd0;
        end else begin
            memtoreg_q <= wb_ctl[0];
            alu_q      <= alu_result;
            rd_q       <= five_bit_muxout;
            case (state_q)
                ST_INIT: begin
                    clr_ptr_q   <= clr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    regwrite_q  <= 1'b0;
                    read_data_q <= 32'h0000_0000;
                    if (&clr_ptr_q) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_INIT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q    <= ST_RUN;
                    busy_q     <= 1'b0;
                    regwrite_q <= wb_ctl[1] & ~bad_s;
                    fault_q    <= fault_q | bad_s;
                    // Read-before-write falls out of the nonblocking memory update.
                    if (memread && !bad_s) begin
                        read_data_q <= mem_q[idx_s];
                    end else begin
                        read_data_q <= 32'h0000_0000;
                    end
                end
                default: begin
                    state_q     <= ST_INIT;
                    clr_ptr_q   <= '0;
                    busy_q      <= 1'b1;
                    regwrite_q  <= 1'b0;
                    read_data_q <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign mem_busy        = busy_q;
    assign mem_fault       = fault_q;
    assign MEM_WB_regwrite = regwrite_q;
    assign MEM_WB_memtoreg = memtoreg_q;
    assign read_data       = read_data_q;
    assign mem_alu_result  = alu_q;
    assign MEM_WB_rd       = rd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// compared against a word-array reference model.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [1:0]  wb_ctl;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2;
    logic [4:0]  five_bit_muxout;
    logic        MEM_PCSrc;
    logic        mem_busy;
    logic        mem_fault;
    logic        MEM_WB_regwrite;
    logic        MEM_WB_memtoreg;
    logic [31:0] read_data;
    logic [31:0] mem_alu_result;
    logic [4:0]  MEM_WB_rd;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .wb_ctl          (wb_ctl),
        .branch          (branch),
        .memread         (memread),
        .memwrite        (memwrite),
        .zero            (zero),
        .alu_result      (alu_result),
        .rdata2          (rdata2),
        .five_bit_muxout (five_bit_muxout),
        .MEM_PCSrc       (MEM_PCSrc),
        .mem_busy        (mem_busy),
        .mem_fault       (mem_fault),
        .MEM_WB_regwrite (MEM_WB_regwrite),
        .MEM_WB_memtoreg (MEM_WB_memtoreg),
        .read_data       (read_data),
        .mem_alu_result  (mem_alu_result),
        .MEM_WB_rd       (MEM_WB_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit          ref_valid = 1'b0;
    int          sweep_left;
    bit [31:0]   ref_mem [256];
    bit          e_fault, e_regwrite, e_memtoreg;
    bit [31:0]   e_read, e_alu;
    bit [4:0]    e_rd;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit [1:0] wb, input bit br, input bit z,
                         input bit mr, input bit mw, input bit [31:0] a,
                         input bit [31:0] d, input bit [4:0] rd);
        rst = r; wb_ctl = wb; branch = br; zero = z;
        memread = mr; memwrite = mw; alu_result = a; rdata2 = d; five_bit_muxout = rd;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    // Apply the rules of one rising edge to the model using the current inputs.
    task automatic model_edge();
        bit bad;
        if (rst) begin
            ref_valid = 1'b1;
            sweep_left = 256;
            e_fault = 0; e_regwrite = 0; e_memtoreg = 0; e_read = 0; e_alu = 0; e_rd = 0;
        end else if (sweep_left > 0) begin
            sweep_left--;
            if (sweep_left == 0) foreach (ref_mem[i]) ref_mem[i] = 32'h0;
            e_regwrite = 0; e_read = 0;
            e_memtoreg = wb_ctl[0]; e_alu = alu_result; e_rd = five_bit_muxout;
        end else begin
            bad = (memread || memwrite) && ((alu_result % 4 != 0) || (alu_result >= 1024));
            e_read = (memread && !bad) ? ref_mem[alu_result / 4] : 32'h0;
            if (memwrite && !bad) ref_mem[alu_result / 4] = rdata2;
            e_regwrite = wb_ctl[1] && !bad;
            e_fault = e_fault || bad;
            e_memtoreg = wb_ctl[0]; e_alu = alu_result; e_rd = five_bit_muxout;
        end
    endtask

    // One clock: check the combinational branch select, clock, then compare all outputs.
    task automatic cycle();
        #1;
        if (ref_valid)
            check_eq("pcsrc", {31'b0, MEM_PCSrc}, {31'b0, (sweep_left == 0) && branch && zero});
        @(posedge clk);
        model_edge();
        #1;
        check_eq("busy",     {31'b0, mem_busy},        {31'b0, sweep_left > 0});
        check_eq("fault",    {31'b0, mem_fault},       {31'b0, e_fault});
        check_eq("regwrite", {31'b0, MEM_WB_regwrite}, {31'b0, e_regwrite});
        check_eq("memtoreg", {31'b0, MEM_WB_memtoreg}, {31'b0, e_memtoreg});
        check_eq("rdata",    read_data,                e_read);
        check_eq("alu",      mem_alu_result,           e_alu);
        check_eq("rd",       {27'b0, MEM_WB_rd},       {27'b0, e_rd});
    endtask

    task automatic finish_sweep(output int busy_edges);
        busy_edges = 0;
        for (int i = 0; i < 300 && mem_busy === 1'b1; i++) begin
            idle();
            cycle();
            busy_edges++;
        end
    endtask

    initial begin
        int n;
        bit [31:0] a;
        // 1: reset and the clear sweep
        drive(1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 32'h4, 32'h5, 5'd3);
        cycle();
        cycle();
        check_eq("rst_busy", {31'b0, mem_busy}, 32'd1);
        drive(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        check_eq("init_pcsrc", {31'b0, MEM_PCSrc}, 32'd0);
        finish_sweep(n);
        check_eq("sweep_len", n, 32'd256);

        // 2: SW then LW
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0); cycle();
        drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 5'd8);        cycle();
        check_eq("lw_data", read_data, 32'hDEADBEEF);
        check_eq("lw_rw",   {31'b0, MEM_WB_regwrite}, 32'd1);
        check_eq("lw_rd",   {27'b0, MEM_WB_rd}, 32'd8);

        // 3: branch select in RUN
        drive(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0); #1;
        check_eq("br_taken", {31'b0, MEM_PCSrc}, 32'd1); cycle();
        drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0); #1;
        check_eq("br_not",   {31'b0, MEM_PCSrc}, 32'd0); cycle();

        // 5: same-cycle load/store is read-before-write
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h11111111, 5'd0); cycle();
        drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h22222222, 5'd1); cycle();
        check_eq("rbw_old", read_data, 32'h11111111);
        drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 5'd1); cycle();
        check_eq("rbw_new", read_data, 32'h22222222);

        // 4: misaligned load faults and the flag is sticky
        drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 5'd4); cycle();
        check_eq("mis_data", read_data, 32'h0);
        check_eq("mis_rw",   {31'b0, MEM_WB_regwrite}, 32'd0);
        check_eq("mis_flt",  {31'b0, mem_fault}, 32'd1);
        for (int i = 0; i < 10; i++) begin idle(); cycle(); end
        check_eq("flt_hold", {31'b0, mem_fault}, 32'd1);

        // 6: reset in the middle of a sweep restarts it
        drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0); cycle();
        for (int i = 0; i < 100; i++) begin idle(); cycle(); end
        drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0); cycle();
        check_eq("rst2_flt", {31'b0, mem_fault}, 32'd0);
        finish_sweep(n);
        check_eq("sweep2_len", n, 32'd256);
        drive(1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3FC, 32'h0, 5'd2); cycle();
        check_eq("top_word", read_data, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = {22'b0, $urandom_range(0, 1023)};
                default: a = {$urandom_range(0, 15), 2'b00};
            endcase
            drive($urandom_range(0, 599) == 0, 2'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom_range(0, 2) == 0, a, $urandom, 5'($urandom));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
